// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: data width and a constant-evaluable ceil(log2) helper.
package uart_tx_fifo_pkg;

   localparam int unsigned UART_DATA_W = 8;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-write, status and transmitter-handshake signals of the UART TX byte FIFO.
interface uart_tx_fifo_if #(
   parameter int unsigned DEPTH = 16
);
   import uart_tx_fifo_pkg::*;

   localparam int unsigned AW = clog2(DEPTH);

   logic                   clr;
   logic                   wr_en;
   logic [UART_DATA_W-1:0] wr_data;
   logic                   full;
   logic                   empty;
   logic [AW:0]            level;
   logic                   overflow;
   logic [UART_DATA_W-1:0] tx_data;
   logic                   tx_data_valid;
   logic                   tx_data_ready;

   // master: host plus transmitter side; slave: the FIFO itself
   modport master (
      output clr, wr_en, wr_data, tx_data_ready,
      input  full, empty, level, overflow, tx_data, tx_data_valid
   );

   modport slave (
      input  clr, wr_en, wr_data, tx_data_ready,
      output full, empty, level, overflow, tx_data, tx_data_valid
   );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte register array: one synchronous write port, one asynchronous read port.
module uart_fifo_mem
   import uart_tx_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                            clk,
   input  logic                            i_we,
   input  logic [clog2(DEPTH)-1:0]         i_waddr,
   input  logic [UART_DATA_W-1:0]          i_wdata,
   input  logic [clog2(DEPTH)-1:0]         i_raddr,
   output logic [UART_DATA_W-1:0]          o_rdata
);

   logic [UART_DATA_W-1:0] r_mem [DEPTH];

   // Storage is deliberately left unreset; validity is tracked by the level counter.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO feeding the UART transmitter over a valid/ready handshake.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_tx_fifo_if.slave fifo_if
);

   localparam int unsigned AW         = clog2(DEPTH);
   localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

   logic [AW-1:0]          r_wr_ptr;
   logic [AW-1:0]          r_rd_ptr;
   logic [AW:0]            r_level;
   logic                   r_full;
   logic                   r_empty;
   logic                   r_overflow;

   logic                   w_push;
   logic                   w_pop;
   logic                   w_mem_we;
   logic [AW-1:0]          w_wr_ptr_d;
   logic [AW-1:0]          w_rd_ptr_d;
   logic [AW:0]            w_level_d;
   logic                   w_overflow_d;
   logic [UART_DATA_W-1:0] w_rd_data;

   // Full is judged on the registered flag, so a push into a full FIFO is
   // rejected even when a pop frees an entry on the same edge.
   assign w_push   = fifo_if.wr_en & ~r_full;
   assign w_pop    = ~r_empty & fifo_if.tx_data_ready;
   assign w_mem_we = w_push & ~fifo_if.clr;

   always_comb begin
      w_wr_ptr_d   = r_wr_ptr;
      w_rd_ptr_d   = r_rd_ptr;
      w_level_d    = r_level;
      w_overflow_d = r_overflow;
      if (fifo_if.clr) begin
         w_wr_ptr_d   = '0;
         w_rd_ptr_d   = '0;
         w_level_d    = '0;
         w_overflow_d = 1'b0;
      end else begin
         if (w_push) begin
            w_wr_ptr_d = r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   w_level_d = r_level + (AW + 1)'(1);
            2'b01:   w_level_d = r_level - (AW + 1)'(1);
            default: w_level_d = r_level;
         endcase
         if (fifo_if.wr_en && r_full) begin
            w_overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         r_wr_ptr   <= w_wr_ptr_d;
         r_rd_ptr   <= w_rd_ptr_d;
         r_level    <= w_level_d;
         r_full     <= (w_level_d == LEVEL_FULL);
         r_empty    <= (w_level_d == '0);
         r_overflow <= w_overflow_d;
      end
   end

   uart_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_mem_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (fifo_if.wr_data),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_data)
   );

   assign fifo_if.full          = r_full;
   assign fifo_if.empty         = r_empty;
   assign fifo_if.level         = r_level;
   assign fifo_if.overflow      = r_overflow;
   assign fifo_if.tx_data_valid = ~r_empty;
   assign fifo_if.tx_data       = w_rd_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH=16) with a simple transmitter ready model.
module tb_uart_tx_fifo;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   uart_tx_fifo_if #(.DEPTH(16)) u_if ();

   uart_tx_fifo #(
      .DEPTH (16)
   ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .fifo_if (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] data);
      u_if.wr_en   = 1'b1;
      u_if.wr_data = data;
      tick();
      u_if.wr_en   = 1'b0;
   endtask

   logic [7:0] t3_exp [3];

   initial begin
      n_vec = 0;
      n_err = 0;
      t3_exp = '{8'h41, 8'h42, 8'h43};
      rst_n = 1'b0;
      u_if.clr = 1'b0;
      u_if.wr_en = 1'b0;
      u_if.wr_data = 8'h00;
      u_if.tx_data_ready = 1'b0;
      tick();
      tick();
      check_eq("rst_level", 32'(u_if.level), 32'd0);
      check_eq("rst_empty", 32'(u_if.empty), 32'd1);
      check_eq("rst_full", 32'(u_if.full), 32'd0);
      check_eq("rst_ovf", 32'(u_if.overflow), 32'd0);
      check_eq("rst_valid", 32'(u_if.tx_data_valid), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single byte, ready held high: visible next cycle, popped on the following edge.
      u_if.tx_data_ready = 1'b1;
      write_byte(8'h55);
      check_eq("t1_valid", 32'(u_if.tx_data_valid), 32'd1);
      check_eq("t1_data", 32'(u_if.tx_data), 32'h55);
      check_eq("t1_level", 32'(u_if.level), 32'd1);
      tick();
      check_eq("t1_empty", 32'(u_if.empty), 32'd1);
      check_eq("t1_level0", 32'(u_if.level), 32'd0);
      check_eq("t1_valid0", 32'(u_if.tx_data_valid), 32'd0);

      // Fill to DEPTH, then one extra write must overflow and be dropped.
      u_if.tx_data_ready = 1'b0;
      for (int i = 0; i < 16; i++) write_byte(8'(i));
      check_eq("t2_full", 32'(u_if.full), 32'd1);
      check_eq("t2_level", 32'(u_if.level), 32'd16);
      check_eq("t2_ovf0", 32'(u_if.overflow), 32'd0);
      check_eq("t2_head", 32'(u_if.tx_data), 32'h00);
      write_byte(8'hAA);
      check_eq("t2_ovf1", 32'(u_if.overflow), 32'd1);
      check_eq("t2_level_hold", 32'(u_if.level), 32'd16);
      u_if.tx_data_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check_eq("t2_drain", 32'(u_if.tx_data), 32'(i));
         tick();
      end
      u_if.tx_data_ready = 1'b0;
      check_eq("t2_empty", 32'(u_if.empty), 32'd1);
      check_eq("t2_ovf_sticky", 32'(u_if.overflow), 32'd1);
      u_if.clr = 1'b1;
      tick();
      u_if.clr = 1'b0;
      check_eq("t2_clr_ovf", 32'(u_if.overflow), 32'd0);

      // Burst of three; transmitter accepts one, drops ready for a frame time, repeats.
      write_byte(8'h41);
      write_byte(8'h42);
      write_byte(8'h43);
      check_eq("t3_level3", 32'(u_if.level), 32'd3);
      for (int j = 0; j < 3; j++) begin
         for (int c = 0; c < 50 && !u_if.tx_data_valid; c++) tick();
         check_eq("t3_valid", 32'(u_if.tx_data_valid), 32'd1);
         check_eq("t3_data", 32'(u_if.tx_data), 32'(t3_exp[j]));
         u_if.tx_data_ready = 1'b1;
         tick();
         u_if.tx_data_ready = 1'b0;
         check_eq("t3_level", 32'(u_if.level), 32'(2 - j));
         for (int c = 0; c < 10; c++) tick();
      end
      check_eq("t3_empty", 32'(u_if.empty), 32'd1);

      // Steady level 4 with push and pop every cycle, crossing the pointer wrap.
      for (int i = 0; i < 4; i++) write_byte(8'h10 + 8'(i));
      check_eq("t4_level_init", 32'(u_if.level), 32'd4);
      for (int k = 0; k < 20; k++) begin
         u_if.wr_en = 1'b1;
         u_if.wr_data = 8'h14 + 8'(k);
         u_if.tx_data_ready = 1'b1;
         check_eq("t4_order", 32'(u_if.tx_data), 32'(8'h10 + 8'(k)));
         tick();
         check_eq("t4_level", 32'(u_if.level), 32'd4);
      end
      u_if.wr_en = 1'b0;
      u_if.tx_data_ready = 1'b0;
      check_eq("t4_head_after", 32'(u_if.tx_data), 32'h24);
      u_if.clr = 1'b1;
      tick();
      u_if.clr = 1'b0;
      check_eq("t4_clr_empty", 32'(u_if.empty), 32'd1);

      // Full FIFO: write plus pop on the same edge -> pop only, write rejected.
      for (int i = 0; i < 16; i++) write_byte(8'h80 + 8'(i));
      check_eq("t5_full", 32'(u_if.full), 32'd1);
      u_if.wr_en = 1'b1;
      u_if.wr_data = 8'hEE;
      u_if.tx_data_ready = 1'b1;
      tick();
      u_if.wr_en = 1'b0;
      check_eq("t5_level", 32'(u_if.level), 32'd15);
      check_eq("t5_ovf", 32'(u_if.overflow), 32'd1);
      check_eq("t5_notfull", 32'(u_if.full), 32'd0);
      for (int i = 1; i < 16; i++) begin
         check_eq("t5_drain", 32'(u_if.tx_data), 32'(8'h80 + 8'(i)));
         tick();
      end
      u_if.tx_data_ready = 1'b0;
      check_eq("t5_empty", 32'(u_if.empty), 32'd1);

      // clr beats a simultaneous write.
      for (int i = 0; i < 5; i++) write_byte(8'h30 + 8'(i));
      check_eq("t6_level5", 32'(u_if.level), 32'd5);
      check_eq("t6_ovf1", 32'(u_if.overflow), 32'd1);
      u_if.clr = 1'b1;
      u_if.wr_en = 1'b1;
      u_if.wr_data = 8'h77;
      tick();
      u_if.clr = 1'b0;
      u_if.wr_en = 1'b0;
      check_eq("t6_clr_level", 32'(u_if.level), 32'd0);
      check_eq("t6_clr_empty", 32'(u_if.empty), 32'd1);
      check_eq("t6_clr_valid", 32'(u_if.tx_data_valid), 32'd0);
      check_eq("t6_clr_ovf", 32'(u_if.overflow), 32'd0);

      // Asynchronous reset in the middle of an overflowing burst.
      for (int i = 0; i < 20; i++) begin
         u_if.wr_en = 1'b1;
         u_if.wr_data = 8'h60 + 8'(i);
         tick();
      end
      check_eq("t7_pre_ovf", 32'(u_if.overflow), 32'd1);
      check_eq("t7_pre_level", 32'(u_if.level), 32'd16);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t7_rst_level", 32'(u_if.level), 32'd0);
      check_eq("t7_rst_empty", 32'(u_if.empty), 32'd1);
      check_eq("t7_rst_full", 32'(u_if.full), 32'd0);
      check_eq("t7_rst_valid", 32'(u_if.tx_data_valid), 32'd0);
      check_eq("t7_rst_ovf", 32'(u_if.overflow), 32'd0);
      u_if.wr_en = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      write_byte(8'h99);
      check_eq("t7_post_data", 32'(u_if.tx_data), 32'h99);
      check_eq("t7_post_level", 32'(u_if.level), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer sitting directly upstream of the UART transmitter. It accepts bytes from the host/CPU side in single-cycle writes and presents them, in order, on a valid/ready interface matching the transmitter's tx_data / tx_data_valid / tx_data_ready ports. It decouples bursty host writes from the slow serial bit rate and reports fill level and overflow.

Parameters:
DEPTH, 16, number of byte entries; power of two, 2..256
AW, log2(DEPTH), pointer width; derived localparam, not overridden

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active low
clr  input  1  synchronous flush; empties FIFO and clears overflow
wr_en  input  1  write strobe, one byte per cycle
wr_data  input  8  byte to enqueue
full  output  1  no free entry
empty  output  1  no stored entry
level  output  AW+1  number of stored entries, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
tx_data  output  8  head-of-queue byte, to transmitter tx_data
tx_data_valid  output  1  head byte valid, to transmitter tx_data_valid
tx_data_ready  input  1  from transmitter; transfer occurs when valid and ready both 1 at a rising clk edge

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, overflow=0, tx_data_valid=0. tx_data value is don't-care while valid=0. Storage array is not reset.
- Reset in mid-operation discards all content; no partial state survives. A byte already latched by the transmitter is unaffected by this block.
- Pointers AW bits, wrap modulo DEPTH; level is a separate AW+1-bit counter; full = (level==DEPTH), empty = (level==0). All flags are registered, consistent with level.
- Write: wr_en=1 and full=0 -> mem[wr_ptr]<=wr_data, wr_ptr+1. wr_en=1 and full=1 -> data dropped, overflow<=1, pointers unchanged.
- Read (pop): tx_data_valid=1 and tx_data_ready=1 at an edge -> rd_ptr+1.
- tx_data_valid = !empty (registered state). tx_data = mem[rd_ptr], show-ahead: valid byte is on tx_data in the same cycle valid is high, with no extra read latency.
- Write-to-valid latency: a byte written into an empty FIFO at edge N shows tx_data_valid=1 from edge N onward, i.e. in the following cycle. It is never combinationally visible in the write cycle.
- Simultaneous push and pop (not full, not empty): both pointers advance and level is unchanged.
- Push when full with a simultaneous pop: the write is still rejected and overflow is set, because full is evaluated on the registered value. Pop proceeds normally.
- Pop while empty is impossible: valid=0.
- tx_data_valid and tx_data stay stable until popped. They never deassert or change without a transfer, except on clr or reset.
- Transmitter drops ready the cycle after accepting a byte and raises it after its stop bit. The FIFO relies only on the valid&&ready rule and makes no timing assumption about ready.
- clr=1 has priority over wr_en and pop in the same cycle: pointers and level go to 0, overflow goes to 0, valid goes to 0 next cycle.
- overflow clears only on clr or reset.

Decomposition:
- Shared package/include: UART_DATA_W=8 (also used by the transmitter and receiver) and a clog2 function for AW.
- One natural sub-module: uart_fifo_mem, a DEPTH x 8 register array with one synchronous write port and one asynchronous read port. The pointer, level and flag logic stays in uart_tx_fifo.
- Downstream connection: tx_data, tx_data_valid and tx_data_ready wire 1:1 to the transmitter.

Test Plan:
- Reset release, then write 0x55 once with tx_data_ready=1 held -> valid rises next cycle with tx_data=0x55; popped at that edge; empty=1 and level=0 one cycle later.
- tx_data_ready=0; write 0x00..0x0F (16 bytes, DEPTH=16) -> full=1, level=16, overflow=0. A 17th write of 0xAA -> overflow=1, level stays 16, and 0xAA is never output.
- Drive the real transmitter (CLK_FRE=1, BAUD_RATE=115200 equivalent divisor). Burst-write 0x41, 0x42, 0x43 -> serial line carries the three frames back to back in order; level steps 3->2->1->0 at each accept.
- Hold level=4 with valid=1, then push and pop in the same cycle for 20 cycles across pointer wrap -> level stays 4 and output order matches input order.
- Full FIFO, wr_en with simultaneous pop -> pop occurs, level=15, overflow=1, written byte discarded.
- level=5, overflow=1; assert clr together with wr_en -> next cycle level=0, empty=1, valid=0, overflow=0. Assert rst_n low mid-burst -> same outputs asynchronously.
